instr_fetch_unit: RTL and testbench

Instruction fetch stage for the 32-bit MIPS-subset core, directly upstream of decode and execute and the consumer of execute's branch outputs (`Addr_result`, `Zero`). It holds the PC and requests one instruction at a time from an instruction memory with a variable-latency req/ack handshake. It presents the instruction to decode until decode accepts it, then computes the next PC:

- sequential PC+4;
- taken branch;
- J/Jal target;
- Jr register target.

It also keeps a retired-instruction counter.

---
 rtl/instr_fetch_unit_if.sv | 22 ++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and the instruction memory (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS-subset fetch stage: PC, variable-latency imem handshake, next-PC select.
// Optional macro IFETCH_ALIGN_CHECK_EN traps a misaligned next PC into HALT.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    instr_fetch_unit_if.master          imem,
    output logic [31:0]                 Instruction,
    output logic                        instr_valid,
    input  logic                        stall,
    output logic [31:0]                 PC_plus_4,
    input  logic [31:0]                 Addr_result,
    input  logic                        Zero,
    input  logic                        Branch,
    input  logic                        nBranch,
    input  logic                        Jmp,
    input  logic                        Jal,
    input  logic                        Jr,
    input  logic [31:0]                 Read_data_1,
    output logic [31:0]                 instr_count,
    output logic                        addr_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        taken;
    logic        unused_bits;

    assign PC_plus_4      = pc + 32'd4;
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    // Priority: Jr, then J/Jal, then conditional branch, then sequential.
    always_comb begin
        taken  = (Branch & Zero) | (nBranch & ~Zero);
        target = PC_plus_4;
        if (Jr)
            target = Read_data_1;
        else if (Jmp || Jal)
            target = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
        else if (taken)
            target = {Addr_result[29:0], 2'b00};
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    assign next_pc     = target;
    assign unused_bits = ^Addr_result[31:30];
`else
    assign next_pc     = {target[31:2], 2'b00};
    assign unused_bits = ^{Addr_result[31:30], target[1:0]};
    assign addr_err    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            Instruction <= '0;
            instr_valid <= 1'b0;
            instr_count <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            addr_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (imem.imem_ack) begin
                        Instruction <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        instr_count <= instr_count + 32'd1;
`ifdef IFETCH_ALIGN_CHECK_EN
                        // Misaligned target: keep the old PC and park in HALT.
                        if (next_pc[1:0] != 2'b00) begin
                            addr_err <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
`else
                        pc    <= next_pc;
                        state <= FETCH;
`endif
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: driver pushes expectations, a
// negedge monitor pops and compares against the DUT.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    always #5 clock = ~clock;

    instr_fetch_unit_if m_if ();
    instr_fetch_unit_if w_if ();

    logic [31:0] Instruction, PC_plus_4, Addr_result, Read_data_1, instr_count;
    logic        instr_valid, stall, Zero, Branch, nBranch, Jmp, Jal, Jr, addr_err;

    logic [31:0] w_instr, w_pc4, w_count;
    logic        w_valid, w_stall, w_err;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem        (m_if),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .stall       (stall),
        .PC_plus_4   (PC_plus_4),
        .Addr_result (Addr_result),
        .Zero        (Zero),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Read_data_1 (Read_data_1),
        .instr_count (instr_count),
        .addr_err    (addr_err)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem        (w_if),
        .Instruction (w_instr),
        .instr_valid (w_valid),
        .stall       (w_stall),
        .PC_plus_4   (w_pc4),
        .Addr_result (32'h0),
        .Zero        (1'b0),
        .Branch      (1'b0),
        .nBranch     (1'b0),
        .Jmp         (1'b0),
        .Jal         (1'b0),
        .Jr          (1'b0),
        .Read_data_1 (32'h0),
        .instr_count (w_count),
        .addr_err    (w_err)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] count;
    } resp_t;

    logic [31:0] addr_q[$];
    resp_t       resp_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=none", name, what);
    endtask

    // Monitor: new requests and presented instructions against the queues.
    logic prev_req = 1'b0;
    logic prev_valid = 1'b0;
    always @(negedge clock) begin
        if (reset_n) begin
            if (m_if.imem_req && !prev_req) begin
                if (addr_q.size() == 0) fail_event("req_unexpected", "request");
                else chk("imem_addr", m_if.imem_addr, addr_q.pop_front());
            end
            if (instr_valid) begin
                if (resp_q.size() == 0) begin
                    fail_event("valid_unexpected", "instr_valid");
                end else begin
                    chk("Instruction", Instruction, resp_q[0].instr);
                    chk("PC_plus_4", PC_plus_4, resp_q[0].pc4);
                    chk("instr_count", instr_count, resp_q[0].count);
                end
            end
            if (prev_valid && !instr_valid && resp_q.size() != 0)
                void'(resp_q.pop_front());
            chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        end
        prev_req   = m_if.imem_req;
        prev_valid = instr_valid;
    end

    function automatic logic [31:0] model_target(
        input logic [31:0] pc, input logic [31:0] w,
        input logic br, input logic nbr, input logic jmp, input logic jal,
        input logic jr, input logic z, input logic [31:0] ar, input logic [31:0] rd1);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jr)                            return rd1;
        if (jmp || jal)                    return (seq & 32'hF000_0000) + ((w & 32'h03FF_FFFF) * 4);
        if ((br && z) || (nbr && !z))      return ar * 4;
        return seq;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_txn(input int lat, input int st, input logic [31:0] w,
                          input logic br, input logic nbr, input logic jmp, input logic jal,
                          input logic jr, input logic z, input logic [31:0] ar, input logic [31:0] rd1);
        int          n;
        logic [31:0] tgt;
        logic        halt;
        n = 0;
        while (!m_if.imem_req && n < 20) begin
            tick();
            n++;
        end
        if (!m_if.imem_req) begin
            fail_event("req_timeout", "no_request");
            return;
        end
        for (int i = 0; i < lat; i++) tick();
        Branch = br; nBranch = nbr; Jmp = jmp; Jal = jal; Jr = jr; Zero = z;
        Addr_result = ar; Read_data_1 = rd1;
        stall = 1'b1;
        m_if.imem_ack = 1'b1;
        m_if.imem_rdata = w;
        resp_q.push_back('{w, m_pc + 32'd4, m_count});
        tick();
        m_if.imem_ack = 1'b0;
        for (int i = 0; i < st; i++) begin
            m_if.imem_ack   = 1'($urandom_range(0, 1));
            m_if.imem_rdata = $urandom;
            tick();
        end
        m_if.imem_ack = 1'b0;
        stall = 1'b0;
        tgt  = model_target(m_pc, w, br, nbr, jmp, jal, jr, z, ar, rd1);
        halt = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        if (tgt % 4 != 0) halt = 1'b1;
`else
        tgt = tgt - (tgt % 4);
`endif
        if (!halt) begin
            addr_q.push_back(tgt);
            m_pc = tgt;
        end
        m_count = m_count + 1;
        tick();
        if (halt) exp_err = 1'b1;
        stall = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        reset_n = 1'b0;
        stall = 1'b1; w_stall = 1'b1;
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
        Addr_result = '0; Read_data_1 = '0;
        m_if.imem_ack = 1'b1;             // ack during reset/IDLE must be ignored
        m_if.imem_rdata = 32'hDEAD_BEEF;
        w_if.imem_ack = 1'b0;
        w_if.imem_rdata = '0;
        m_pc = 32'h0; m_count = 32'h0;

        repeat (2) @(negedge clock);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_req", {31'b0, m_if.imem_req}, 32'h0);
        chk("rst_addr", m_if.imem_addr, 32'h0);
        chk("rst_pc4", PC_plus_4, 32'h4);
        chk("rst_err", {31'b0, addr_err}, 32'h0);

        addr_q.push_back(32'h0);
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        chk("idle_req", {31'b0, m_if.imem_req}, 32'h0);
        tick();
        m_if.imem_ack = 1'b0;

        // Directed: first fetch, stalled fetch, branches, jumps.
        do_txn(0, 0, 32'h2008_0005, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_txn(3, 4, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_txn(1, 0, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_txn(0, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_txn(0, 0, 32'h1000_0002, 1, 0, 0, 0, 0, 1, 32'h8, 32'h0);
        do_txn(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
        do_txn(2, 0, 32'h1000_0002, 1, 0, 0, 0, 0, 0, 32'h8, 32'h0);
        do_txn(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h10);
        do_txn(0, 2, 32'h1400_0002, 0, 1, 0, 0, 0, 0, 32'h8, 32'h0);
        do_txn(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h4000_0000);
        do_txn(1, 0, 32'h0C00_0010, 0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        do_txn(0, 0, 32'h0800_0123, 0, 0, 1, 0, 1, 0, 32'h0, 32'h100);

        for (int t = 0; t < 40; t++) begin
            rd = $urandom;
`ifdef IFETCH_ALIGN_CHECK_EN
            rd = rd & 32'hFFFF_FFFC;
`endif
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), $urandom,
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   $urandom, rd);
        end

        // Misaligned Jr target.
        do_txn(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 32'h102);
`ifdef IFETCH_ALIGN_CHECK_EN
        tick();
        chk("halt_req", {31'b0, m_if.imem_req}, 32'h0);
        chk("halt_err", {31'b0, addr_err}, 32'h1);
        chk("halt_count", instr_count, m_count);
        m_if.imem_ack = 1'b1;
        m_if.imem_rdata = 32'hCAFE_F00D;
        repeat (3) tick();
        m_if.imem_ack = 1'b0;
        chk("halt_valid", {31'b0, instr_valid}, 32'h0);
        chk("halt_req2", {31'b0, m_if.imem_req}, 32'h0);
`else
        repeat (2) tick();
`endif
        chk("addr_q_drained", addr_q.size(), 32'h0);

        // Wrap instance: PC = FFFF_FFFC, sequential consume rolls to 0.
        chk("wrap_req", {31'b0, w_if.imem_req}, 32'h1);
        chk("wrap_addr", w_if.imem_addr, 32'hFFFF_FFFC);
        w_if.imem_ack = 1'b1;
        w_if.imem_rdata = 32'h0000_0000;
        tick();
        w_if.imem_ack = 1'b0;
        chk("wrap_valid", {31'b0, w_valid}, 32'h1);
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_instr", w_instr, 32'h0);
        w_stall = 1'b0;
        tick();
        w_stall = 1'b1;
        chk("wrap_next_req", {31'b0, w_if.imem_req}, 32'h1);
        chk("wrap_next_addr", w_if.imem_addr, 32'h0);
        chk("wrap_count", w_count, 32'h1);
        chk("wrap_err", {31'b0, w_err}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
